// File: rtl/aoi_sweep_ctrl.sv
// Self-test sequencer that sweeps all 16 inputs of the AOI unit (e=a&b, f=c&d, g=~(e|f)) and checks its outputs.
// Optional build macro: AOI_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module aoi_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a_o,
  output logic       b_o,
  output logic       c_o,
  output logic       d_o,
  input  logic       e_i,
  input  logic       f_i,
  input  logic       g_i,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic [3:0] vec_idx,
  output logic       fail_valid,
  output logic [3:0] fail_vec,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, CHECK = 2'd2, DONE = 2'd3} state_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] vec_q, vec_d;
  logic [4:0] err_q, err_d;
  logic [3:0] fvec_q, fvec_d;
  logic       fv_q, fv_d;
  logic       pass_q, pass_d;

  logic       ref_e, ref_f, ref_g;
  logic       mismatch;
  logic       last_vec;
  logic [4:0] err_next;

  assign ref_e    = vec_q[3] & vec_q[2];
  assign ref_f    = vec_q[1] & vec_q[0];
  assign ref_g    = ~(ref_e | ref_f);
  assign mismatch = ({e_i, f_i, g_i} != {ref_e, ref_f, ref_g});
  assign err_next = err_q + {4'd0, mismatch};

`ifdef AOI_SWEEP_STOP_ON_FAIL_EN
  assign last_vec = (vec_q == 4'hf) || mismatch;
`else
  assign last_vec = (vec_q == 4'hf);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      fvec_q  <= '0;
      fv_q    <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
      fv_q    <= fv_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    err_d   = err_q;
    fvec_d  = fvec_q;
    fv_d    = fv_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = '0;
          vec_d   = '0;
          err_d   = '0;
          fvec_d  = '0;
          fv_d    = 1'b0;
          pass_d  = 1'b0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == LAST_CNT) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      CHECK: begin
        err_d = err_next;
        if (mismatch && !fv_q) begin
          fv_d   = 1'b1;
          fvec_d = vec_q;
        end
        // The vector stays on the pins through DONE/IDLE; only a new SETTLE entry moves it.
        if (last_vec) begin
          pass_d  = (err_next == 5'd0);
          state_d = DONE;
        end else begin
          vec_d   = vec_q + 4'd1;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign {a_o, b_o, c_o, d_o} = vec_q;
  assign vec_idx    = vec_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign fail_valid = fv_q;
  assign fail_vec   = fvec_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_aoi_sweep_ctrl.sv
// Bench for aoi_sweep_ctrl: a behavioural AOI model with injectable per-vector output faults,
// table-driven fault scenarios, randomized fault patterns, start-hold and mid-sweep reset sequences.
module tb_aoi_sweep_ctrl;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       a_o, b_o, c_o, d_o;
  logic       e_i, f_i, g_i;
  logic       busy, done, pass, fail_valid;
  logic [4:0] err_cnt;
  logic [3:0] vec_idx, fail_vec;
  logic [1:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  // 3-bit xor mask {e,f,g} per vector, applied to the golden AOI outputs.
  logic [47:0] fault_bits = '0;
  logic [3:0]  drv_v;

  aoi_sweep_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_o(a_o), .b_o(b_o), .c_o(c_o), .d_o(d_o),
    .e_i(e_i), .f_i(f_i), .g_i(g_i),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .vec_idx(vec_idx), .fail_valid(fail_valid), .fail_vec(fail_vec),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always_comb begin
    drv_v = {a_o, b_o, c_o, d_o};
    e_i = (a_o & b_o) ^ fault_bits[int'(drv_v) * 3 + 2];
    f_i = (c_o & d_o) ^ fault_bits[int'(drv_v) * 3 + 1];
    g_i = ~((a_o & b_o) | (c_o & d_o)) ^ fault_bits[int'(drv_v) * 3];
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // kind: 0 none, 1 g stuck 0, 2 e stuck 1, 3 f stuck 0, 4 e stuck 0, 5 random
  task automatic set_fault(input int kind);
    bit ge, gf, gg;
    logic [2:0] m;
    for (int v = 0; v < 16; v++) begin
      ge = (v / 8) % 2 == 1 && (v / 4) % 2 == 1;
      gf = (v / 2) % 2 == 1 && v % 2 == 1;
      gg = !(ge || gf);
      case (kind)
        1: m = {2'b00, gg};
        2: m = {!ge, 2'b00};
        3: m = {1'b0, gf, 1'b0};
        4: m = {ge, 2'b00};
        5: m = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        default: m = 3'd0;
      endcase
      fault_bits[v * 3 +: 3] = m;
    end
  endtask

  // Runs one sweep and checks it against the expected result of a full (non-stopping) sweep.
  task automatic run_sweep(input string name, input int full_err, input bit exp_fv,
                           input int exp_fvec, input bit exp_pass, input bit hold);
    int exp_err, last, lat, j, bad_seq, bad_busy, expv;
    bit seen;
    exp_err = full_err;
    last = 15;
`ifdef AOI_SWEEP_STOP_ON_FAIL_EN
    if (exp_fv) begin
      exp_err = 1;
      last = exp_fvec;
    end
`endif
    lat = (last + 1) * (S + 1);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    check($sformatf("%s clr_err", name), int'(err_cnt), 0);
    check($sformatf("%s clr_fv", name), int'(fail_valid), 0);
    j = 0; bad_seq = 0; bad_busy = 0; seen = 0;
    while (j <= 400) begin
      expv = (j / (S + 1) < last) ? j / (S + 1) : last;
      if (int'(vec_idx) != expv || int'({a_o, b_o, c_o, d_o}) != expv) bad_seq++;
      if (!busy) bad_busy++;
      if (done) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      #1;
      j++;
    end
    check($sformatf("%s done_seen", name), int'(seen), 1);
    check($sformatf("%s latency", name), j, lat);
    check($sformatf("%s vec_seq_bad", name), bad_seq, 0);
    check($sformatf("%s busy_low", name), bad_busy, 0);
    check($sformatf("%s err_cnt", name), int'(err_cnt), exp_err);
    @(posedge clk);
    #1;
    check($sformatf("%s done_pulse", name), int'(done), 0);
    check($sformatf("%s busy_idle", name), int'(busy), 0);
    check($sformatf("%s pass", name), int'(pass), int'(exp_pass));
    check($sformatf("%s fail_valid", name), int'(fail_valid), int'(exp_fv));
    check($sformatf("%s fail_vec", name), int'(fail_vec), exp_fv ? exp_fvec : 0);
    check($sformatf("%s vec_hold", name), int'({a_o, b_o, c_o, d_o}), last);
  endtask

  task automatic check_all_zero(input string name);
    check($sformatf("%s outs", name),
          int'({a_o, b_o, c_o, d_o, busy, done, pass, fail_valid}), 0);
    check($sformatf("%s err_cnt", name), int'(err_cnt), 0);
    check($sformatf("%s vec_idx", name), int'(vec_idx), 0);
    check($sformatf("%s fail_vec", name), int'(fail_vec), 0);
    check($sformatf("%s state", name), int'(state_dbg), 0);
  endtask

  typedef struct {
    string name;
    int    kind;
    int    err;
    bit    fv;
    int    fvec;
    bit    pass;
  } scen_t;

  scen_t tbl[5];

  initial begin
    int m_err, m_first;
    tbl[0] = '{"golden", 0, 0,  1'b0, 0,  1'b1};
    tbl[1] = '{"g_sa0",  1, 9,  1'b1, 0,  1'b0};
    tbl[2] = '{"e_sa1",  2, 12, 1'b1, 0,  1'b0};
    tbl[3] = '{"f_sa0",  3, 4,  1'b1, 3,  1'b0};
    tbl[4] = '{"e_sa0",  4, 4,  1'b1, 12, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      set_fault(tbl[i].kind);
      run_sweep(tbl[i].name, tbl[i].err, tbl[i].fv, tbl[i].fvec, tbl[i].pass, 1'b0);
    end

    // Random fault patterns scored by counting faulty vectors directly.
    for (int r = 0; r < 6; r++) begin
      set_fault(5);
      m_err = 0;
      m_first = -1;
      for (int v = 0; v < 16; v++) begin
        if (fault_bits[v * 3 +: 3] != 3'd0) begin
          m_err++;
          if (m_first < 0) m_first = v;
        end
      end
      run_sweep($sformatf("rand%0d", r), m_err, m_first >= 0, (m_first >= 0) ? m_first : 0,
                m_err == 0, 1'b0);
    end

    // start held high: ignored while busy, then a fresh sweep from the IDLE cycle after DONE.
    set_fault(1);
    run_sweep("hold1", 9, 1'b1, 0, 1'b0, 1'b1);
    set_fault(0);
    run_sweep("hold2", 0, 1'b0, 0, 1'b1, 1'b1);
    @(negedge clk) start = 1'b0;
    repeat (60) @(posedge clk);

    // Reset 20 cycles into a sweep clears everything asynchronously.
    set_fault(1);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk) rst_n = 1'b1;
    set_fault(0);
    run_sweep("after_rst", 0, 1'b0, 0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
